// File: rtl/serial_parallel_rx.sv
// serial_parallel_rx
// ------------------
// Deserializer for the stream produced by an upstream parallel-to-serial
// converter. A frame is W bits sent LSB first. Only bits qualified by sen
// are taken. start marks the qualified bit as bit 0 of a new word. The
// completed word appears on pout on the edge that samples the last bit,
// with no extra pipeline stage.
//
// Ports
//   clk       in   clock; all state changes on posedge
//   clear     in   synchronous active-high reset; overrides every other input
//   sin       in   serial data bit
//   sen       in   serial bit valid (sin and start are ignored when low)
//   start     in   frame marker; the current sin is bit 0 of a new word
//   pout      out  [W-1:0] last completed word, registered
//   valid     out  one-cycle pulse when pout takes a new word
//   busy      out  high while a frame is partly received
//   frame_err out  one-cycle pulse when a new start cuts off a partial frame
//   wcount    out  [3:0] number of completed words, modulo 16
module serial_parallel_rx #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         sin,
   input  logic         sen,
   input  logic         start,
   output logic [W-1:0] pout,
   output logic         valid,
   output logic         busy,
   output logic         frame_err,
   output logic [3:0]   wcount
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_shift;
   logic [W-1:0]   r_pout;
   logic           r_valid;
   logic           r_ferr;
   logic [3:0]     r_wcount;

   // control decodes from the output process
   logic           w_load;   // take sin as bit 0 of a new frame
   logic           w_shift;  // take sin as a middle bit
   logic           w_done;   // take sin as the last bit and publish the word
   logic           w_abort;  // new start while a frame was in progress
   logic           w_last;

   assign w_last = (r_cnt == CW'(W - 1));

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (clear) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // ---- next-state logic ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (sen && start) w_next = SHIFT;
         end
         SHIFT: begin
            // start wins over completion, so a restart keeps us in SHIFT
            if (sen && !start && w_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ---- output / control decode ----
   always_comb begin
      busy    = (r_state == SHIFT);
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         IDLE: begin
            // stray qualified bits without start are dropped
            w_load = sen && start;
         end
         SHIFT: begin
            if (sen) begin
               if (start) begin
                  w_load  = 1'b1;
                  w_abort = 1'b1;
               end else if (w_last) begin
                  w_done  = 1'b1;
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // ---- datapath ----
   // Bits enter at the top and move right, so after W bits the first one
   // received sits at position 0. A freshly loaded bit 0 is placed at the top
   // and walks down with each following bit.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_cnt    <= '0;
         r_shift  <= '0;
         r_pout   <= '0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
         r_wcount <= '0;
      end else begin
         r_valid <= w_done;
         r_ferr  <= w_abort;
         if (w_load) begin
            r_shift <= {sin, {(W-1){1'b0}}};
            r_cnt   <= CW'(1);
         end else if (w_shift) begin
            r_shift <= {sin, r_shift[W-1:1]};
            r_cnt   <= r_cnt + CW'(1);
         end else if (w_done) begin
            r_pout   <= {sin, r_shift[W-1:1]};
            r_shift  <= '0;
            r_cnt    <= '0;
            r_wcount <= r_wcount + 4'd1;
         end
      end
   end

   assign pout      = r_pout;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign wcount    = r_wcount;

endmodule

// File: tb/tb_serial_parallel_rx.sv
module tb_serial_parallel_rx;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       sin = 1'b0;
   logic       sen = 1'b0;
   logic       start = 1'b0;
   logic [5:0] pout;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic [3:0] wcount;

   int n_chk = 0;
   int n_fail = 0;

   serial_parallel_rx #(.W(6)) dut (
      .clk(clk), .clear(clear), .sin(sin), .sen(sen), .start(start),
      .pout(pout), .valid(valid), .busy(busy), .frame_err(frame_err),
      .wcount(wcount)
   );

   always #5 clk = ~clk;

   // drive inputs, take one posedge, then settle 1 time unit before sampling
   task automatic step(input logic en, input logic st, input logic b, input logic cl);
      sen = en; start = st; sin = b; clear = cl;
      @(posedge clk);
      #1;
      sen = 1'b0; start = 1'b0; sin = 1'b0; clear = 1'b0;
   endtask

   task automatic test_reset;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_chk++; if (pout !== 6'd0)    begin n_fail++; $display("FAIL reset_pout got %b exp 000000", pout); end
      n_chk++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
      n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      n_chk++; if (wcount !== 4'd0)  begin n_fail++; $display("FAIL reset_wcount got %0d exp 0", wcount); end
   endtask

   task automatic test_basic;
      logic [5:0] bits;
      int busy_cnt;
      bits = 6'b111010;  // bit i sent on step i: 0,1,0,1,1,1
      busy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, i == 0, bits[i], 1'b0);
         if (busy === 1'b1) busy_cnt++;
         if (i < 5) begin
            n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid bit %0d got %b exp 0", i, valid); end
         end
      end
      n_chk++; if (valid !== 1'b1)    begin n_fail++; $display("FAIL basic_valid got %b exp 1", valid); end
      n_chk++; if (pout !== 6'b111010) begin n_fail++; $display("FAIL basic_pout got %b exp 111010", pout); end
      n_chk++; if (wcount !== 4'd1)   begin n_fail++; $display("FAIL basic_wcount got %0d exp 1", wcount); end
      n_chk++; if (busy_cnt != 5)     begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp 5", busy_cnt); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if (valid !== 1'b0)    begin n_fail++; $display("FAIL basic_valid_pulse got %b exp 0", valid); end
      n_chk++; if (pout !== 6'b111010) begin n_fail++; $display("FAIL basic_pout_hold got %b exp 111010", pout); end
   endtask

   task automatic test_stall;
      logic [5:0] bits;
      bits = 6'b111010;
      for (int i = 0; i < 3; i++) step(1'b1, i == 0, bits[i], 1'b0);
      for (int s = 0; s < 3; s++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         n_chk++; if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold cyc %0d busy %b valid %b exp busy 1 valid 0", s, busy, valid);
         end
      end
      for (int i = 3; i < 6; i++) step(1'b1, 1'b0, bits[i], 1'b0);
      n_chk++; if (valid !== 1'b1 || pout !== 6'b111010) begin
         n_fail++; $display("FAIL stall_word valid %b pout %b exp 1 111010", valid, pout);
      end
      n_chk++; if (wcount !== 4'd2) begin n_fail++; $display("FAIL stall_wcount got %0d exp 2", wcount); end
   endtask

   task automatic test_restart;
      logic [5:0] bits;
      bits = 6'b101101;  // sent 1,0,1,1,0,1
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, i == 0, bits[i], 1'b0);
         if (i == 0) begin
            n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL restart_ferr got %b exp 1", frame_err); end
            n_chk++; if (valid !== 1'b0 || pout !== 6'b111010 || wcount !== 4'd2 || busy !== 1'b1) begin
               n_fail++; $display("FAIL restart_keep valid %b pout %b wcount %0d busy %b exp 0 111010 2 1", valid, pout, wcount, busy);
            end
         end else if (i == 1) begin
            n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL restart_ferr_pulse got %b exp 0", frame_err); end
         end
      end
      n_chk++; if (valid !== 1'b1 || pout !== 6'b101101) begin
         n_fail++; $display("FAIL restart_word valid %b pout %b exp 1 101101", valid, pout);
      end
      n_chk++; if (wcount !== 4'd3) begin n_fail++; $display("FAIL restart_wcount got %0d exp 3", wcount); end
   endtask

   task automatic test_stray;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, i[0], 1'b0);
         n_chk++; if (busy !== 1'b0 || valid !== 1'b0 || pout !== 6'b101101 || wcount !== 4'd3) begin
            n_fail++; $display("FAIL stray cyc %0d busy %b valid %b pout %b wcount %0d exp 0 0 101101 3", i, busy, valid, pout, wcount);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] word;
      int nvalid, nferr;
      nvalid = 0; nferr = 0;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 17; f++) begin
         word = 6'((f * 5 + 3) % 64);
         for (int b = 0; b < 6; b++) begin
            step(1'b1, b == 0, word[b], 1'b0);
            if (valid === 1'b1) nvalid++;
            if (frame_err === 1'b1) nferr++;
         end
         n_chk++; if (valid !== 1'b1 || pout !== word) begin
            n_fail++; $display("FAIL b2b_word frame %0d valid %b pout %b exp 1 %b", f, valid, pout, word);
         end
      end
      n_chk++; if (nvalid != 17) begin n_fail++; $display("FAIL b2b_valid_count got %0d exp 17", nvalid); end
      n_chk++; if (nferr != 0)   begin n_fail++; $display("FAIL b2b_ferr_count got %0d exp 0", nferr); end
      n_chk++; if (wcount !== 4'd1) begin n_fail++; $display("FAIL b2b_wcount got %0d exp 1", wcount); end
   endtask

   task automatic test_clear_mid;
      logic [5:0] bits;
      bits = 6'b000111;  // sent 1,1,1,0,0,0
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);  // clear on bit 4
      n_chk++; if (pout !== 6'd0 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || wcount !== 4'd0) begin
         n_fail++; $display("FAIL clear_mid pout %b valid %b busy %b ferr %b wcount %0d exp all 0", pout, valid, busy, frame_err, wcount);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, i == 0, bits[i], 1'b0);
         if (i == 0) begin
            n_chk++; if (busy !== 1'b1 || frame_err !== 1'b0) begin
               n_fail++; $display("FAIL clear_restart busy %b ferr %b exp 1 0", busy, frame_err);
            end
         end
      end
      n_chk++; if (valid !== 1'b1 || pout !== 6'b000111 || wcount !== 4'd1) begin
         n_fail++; $display("FAIL clear_word valid %b pout %b wcount %0d exp 1 000111 1", valid, pout, wcount);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic;
      test_stall;
      test_restart;
      test_stray;
      test_back_to_back;
      test_clear_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
